// File: rtl/agc_pkg.sv
// Shared definitions for the AGC slot sequencer: FSM state encoding, unity
// gain and the default gain-word geometry.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SLOT   = 2'd2,
    ST_LOCKED = 2'd3
  } agc_state_e;

  // Unity gain in unsigned Q4.8.
  localparam int UNITY_GAIN = 32'h100;

  // Default gain word width (Q4.8) and integer saturation ceiling.
  localparam int AGC_GAIN_W       = 12;
  localparam int AGC_MAX_GAIN_INT = 8;

endpackage

// File: rtl/agc_gain_sat.sv
// Combinational saturation of a raw 24-bit estimator gain into a GAIN_W
// unsigned Q4.8 gain word. Bit 23 flags estimator overflow, [22:8] is the
// integer part, [7:0] the fraction. Anything flagged or above MAX_GAIN_INT
// is clamped to MAX_GAIN_INT<<8.
module agc_gain_sat
  import agc_pkg::*;
#(
  parameter int GAIN_W       = AGC_GAIN_W,
  parameter int MAX_GAIN_INT = AGC_MAX_GAIN_INT
) (
  input  logic [23:0]       est_gain,
  output logic [GAIN_W-1:0] gain_sat
);

  localparam logic [31:0]       MAX_INT_U = 32'(MAX_GAIN_INT);
  localparam logic [GAIN_W-1:0] CEILING   = GAIN_W'(MAX_GAIN_INT * 256);

  function automatic logic [GAIN_W-1:0] sat_gain(input logic [23:0] x);
    logic [31:0] int_part;
    int_part = {17'd0, x[22:8]};
    if (x[23] || (int_part > MAX_INT_U)) begin
      return CEILING;
    end
    return x[GAIN_W-1:0];
  endfunction

  assign gain_sat = sat_gain(est_gain);

endmodule

// File: rtl/agc_slot_sequencer.sv
// AGC slot sequencer: tracks the estimator gain between slots, freezes the
// applied gain for the duration of a slot and swaps in the captured gain at
// each slot boundary.
// Optional build macro AGC_SEQ_WATCHDOG_EN adds a per-slot watchdog that
// abandons a slot after TIMEOUT_CYCLES cycles without a slot boundary.
module agc_slot_sequencer
  import agc_pkg::*;
#(
  parameter int GAIN_W         = AGC_GAIN_W,
  parameter int MAX_GAIN_INT   = AGC_MAX_GAIN_INT,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [23:0]       est_gain,
  input  logic              est_valid,
  input  logic              slot_detected,
  input  logic              slot_finished,
  output logic [GAIN_W-1:0] gain_apply,
  output logic [GAIN_W-1:0] gain_capture,
  output logic              gain_update,
  output logic              locked,
  output logic [1:0]        state,
  output logic              timeout
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(UNITY_GAIN);

  agc_state_e        state_q, state_d;
  logic [GAIN_W-1:0] latest_q, latest_d;
  logic [GAIN_W-1:0] est_sat;
  logic [GAIN_W-1:0] apply_d, capture_d;
  logic              update_d, locked_d;
  logic              timeout_d;

`ifdef AGC_SEQ_WATCHDOG_EN
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  // The watchdog limit has no consumer when the watchdog is compiled out.
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  agc_gain_sat #(
    .GAIN_W       (GAIN_W),
    .MAX_GAIN_INT (MAX_GAIN_INT)
  ) u_gain_sat (
    .est_gain (est_gain),
    .gain_sat (est_sat)
  );

  assign state = state_q;

  // Next-state and next-output decode; latest_d doubles as the capture source
  // so a sample arriving on a capture cycle is taken immediately.
  always_comb begin
    state_d   = state_q;
    apply_d   = gain_apply;
    capture_d = gain_capture;
    update_d  = 1'b0;
    locked_d  = locked;
    timeout_d = 1'b0;
`ifdef AGC_SEQ_WATCHDOG_EN
    wd_d      = '0;
`endif
    latest_d  = est_valid ? est_sat : latest_q;

    if (!enable) begin
      state_d  = ST_IDLE;
      apply_d  = UNITY;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_TRACK;
          apply_d  = UNITY;
          locked_d = 1'b0;
        end
        ST_TRACK: begin
          capture_d = latest_d;
          apply_d   = gain_capture;
          if (slot_detected) begin
            state_d  = ST_SLOT;
            locked_d = 1'b1;
          end
        end
        ST_SLOT: begin
          if (slot_finished) begin
            apply_d  = gain_capture;
            update_d = 1'b1;
            if (slot_detected) begin
              // Back-to-back slots: retire the old capture, start a new one.
              capture_d = latest_d;
            end else begin
              state_d = ST_LOCKED;
            end
          end else if (slot_detected) begin
            capture_d = latest_d;
          end else begin
`ifdef AGC_SEQ_WATCHDOG_EN
            if (wd_q == WD_LIMIT - 1'b1) begin
              timeout_d = 1'b1;
              locked_d  = 1'b0;
              state_d   = ST_TRACK;
            end else if (wd_q != WD_LIMIT) begin
              wd_d = wd_q + 1'b1;
            end else begin
              wd_d = wd_q;
            end
`endif
          end
        end
        ST_LOCKED: begin
          if (slot_detected) begin
            capture_d = latest_d;
            state_d   = ST_SLOT;
            locked_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          apply_d = UNITY;
        end
      endcase
    end
  end

  // State and output registers; reset wins over every input in its cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      gain_apply   <= UNITY;
      gain_capture <= UNITY;
      latest_q     <= UNITY;
      locked       <= 1'b0;
      gain_update  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_apply   <= apply_d;
      gain_capture <= capture_d;
      latest_q     <= latest_d;
      locked       <= locked_d;
      gain_update  <= update_d;
    end
  end

`ifdef AGC_SEQ_WATCHDOG_EN
  // Slot watchdog counter and its single-cycle expiry pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_q    <= '0;
      timeout <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = timeout_d;
`endif

endmodule

// File: tb/tb_agc_slot_sequencer.sv
// Scoreboard bench for agc_slot_sequencer: a behavioural model predicts the
// outputs after every clock edge, a monitor process compares them.
// Honours AGC_SEQ_WATCHDOG_EN the same way the design does.
module tb_agc_slot_sequencer;

  localparam int GAIN_W       = 12;
  localparam int MAX_GAIN_INT = 8;
  localparam int TIMEOUT      = 16;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              enable = 1'b0;
  logic [23:0]       est_gain = '0;
  logic              est_valid = 1'b0;
  logic              slot_detected = 1'b0;
  logic              slot_finished = 1'b0;
  logic [GAIN_W-1:0] gain_apply;
  logic [GAIN_W-1:0] gain_capture;
  logic              gain_update;
  logic              locked;
  logic [1:0]        state;
  logic              timeout;

  agc_slot_sequencer #(
    .GAIN_W         (GAIN_W),
    .MAX_GAIN_INT   (MAX_GAIN_INT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .est_gain      (est_gain),
    .est_valid     (est_valid),
    .slot_detected (slot_detected),
    .slot_finished (slot_finished),
    .gain_apply    (gain_apply),
    .gain_capture  (gain_capture),
    .gain_update   (gain_update),
    .locked        (locked),
    .state         (state),
    .timeout       (timeout)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int apply;
    int capture;
    int upd;
    int lck;
    int st;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model state (spec encoding: IDLE=0 TRACK=1 SLOT=2 LOCKED=3).
  int m_state, m_apply, m_capture, m_latest, m_locked, m_wd, m_upd, m_to;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int ref_sat(input logic [23:0] x);
    int ip;
    ip = int'(x[22:8]);
    if (x[23] || ip > MAX_GAIN_INT) return MAX_GAIN_INT * 256;
    return int'(x) % (1 << GAIN_W);
  endfunction

  task automatic model_step(input logic en, input logic ev, input logic [23:0] eg,
                            input logic sd, input logic sf, input logic rst);
    int newest;
    int old_cap;
    bit wd_on;
`ifdef AGC_SEQ_WATCHDOG_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    m_upd = 0;
    m_to  = 0;
    if (rst) begin
      m_state = 0; m_apply = 'h100; m_capture = 'h100; m_latest = 'h100;
      m_locked = 0; m_wd = 0;
      return;
    end
    newest  = ev ? ref_sat(eg) : m_latest;
    old_cap = m_capture;
    m_latest = newest;
    if (!en) begin
      m_state = 0; m_apply = 'h100; m_locked = 0; m_wd = 0;
      return;
    end
    if (m_state == 0) begin
      m_state = 1; m_apply = 'h100; m_locked = 0;
    end else if (m_state == 1) begin
      m_capture = newest;
      m_apply   = old_cap;
      if (sd) begin m_state = 2; m_locked = 1; end
    end else if (m_state == 2) begin
      if (sf) begin
        m_apply = old_cap; m_upd = 1;
        if (sd) m_capture = newest; else m_state = 3;
        m_wd = 0;
      end else if (sd) begin
        m_capture = newest; m_wd = 0;
      end else if (wd_on) begin
        m_wd++;
        if (m_wd >= TIMEOUT) begin
          m_to = 1; m_locked = 0; m_state = 1; m_wd = 0;
        end
      end
    end else begin
      if (sd) begin m_capture = newest; m_state = 2; m_locked = 1; end
    end
    if (m_state != 2) m_wd = 0;
  endtask

  // Drive one cycle of inputs, predict the outcome of the coming edge, and
  // return shortly after that edge so callers can inspect outputs.
  task automatic cyc(input logic en, input logic ev, input logic [23:0] eg,
                     input logic sd, input logic sf, input logic rst);
    exp_t e;
    @(negedge aclk);
    enable = en; est_valid = ev; est_gain = eg;
    slot_detected = sd; slot_finished = sf; areset = rst;
    model_step(en, ev, eg, sd, sf, rst);
    e.apply = m_apply; e.capture = m_capture; e.upd = m_upd;
    e.lck = m_locked; e.st = m_state; e.to = m_to;
    exp_q.push_back(e);
    @(posedge aclk);
    #2;
  endtask

  // Monitor: every edge with a pending prediction is compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_gain_apply",   int'(gain_apply),   e.apply);
        check("sb_gain_capture", int'(gain_capture), e.capture);
        check("sb_gain_update",  int'(gain_update),  e.upd);
        check("sb_locked",       int'(locked),       e.lck);
        check("sb_state",        int'(state),        e.st);
        check("sb_timeout",      int'(timeout),      e.to);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [23:0] eg;
    int          pct;
    // Reset values
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_apply", int'(gain_apply), 'h100);
    check("rst_capture", int'(gain_capture), 'h100);
    check("rst_state", int'(state), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_timeout", int'(timeout), 0);

    // First valid sample reaches gain_apply through the capture stage
    cyc(1, 1, 24'h000180, 0, 0, 0);
    check("trk_enter_state", int'(state), 1);
    cyc(1, 1, 24'h000180, 0, 0, 0);
    check("trk_capture_180", int'(gain_capture), 'h180);
    cyc(1, 1, 24'h000180, 0, 0, 0);
    check("trk_apply_180", int'(gain_apply), 'h180);

    // Saturation of large and overflowed estimates
    cyc(1, 1, 24'h000A00, 0, 0, 0);
    check("sat_int_over", int'(gain_capture), 'h800);
    cyc(1, 1, 24'h800000, 0, 0, 0);
    check("sat_ovf_bit", int'(gain_capture), 'h800);

    // Slot capture, hold, and boundary update
    cyc(1, 1, 24'h000200, 1, 0, 0);
    check("slot_state", int'(state), 2);
    check("slot_capture", int'(gain_capture), 'h200);
    check("slot_locked", int'(locked), 1);
    cyc(1, 1, 24'h000300, 0, 0, 0);
    check("slot_apply_hold", int'(gain_apply), 'h800);
    check("slot_capture_hold", int'(gain_capture), 'h200);
    cyc(1, 0, 0, 0, 1, 0);
    check("fin_apply", int'(gain_apply), 'h200);
    check("fin_update", int'(gain_update), 1);
    check("fin_state", int'(state), 3);
    cyc(1, 0, 0, 0, 0, 0);
    check("fin_update_pulse", int'(gain_update), 0);

    // Simultaneous slot end and new slot start
    cyc(1, 1, 24'h000200, 1, 0, 0);
    check("b2b_enter", int'(state), 2);
    cyc(1, 1, 24'h000140, 1, 1, 0);
    check("b2b_apply", int'(gain_apply), 'h200);
    check("b2b_capture", int'(gain_capture), 'h140);
    check("b2b_state", int'(state), 2);
    check("b2b_update", int'(gain_update), 1);

    // Watchdog behaviour
`ifdef AGC_SEQ_WATCHDOG_EN
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, 0, 0, 0, 0, 0);
    check("wd_before_state", int'(state), 2);
    check("wd_before_to", int'(timeout), 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("wd_pulse", int'(timeout), 1);
    check("wd_state", int'(state), 1);
    check("wd_locked", int'(locked), 0);
    check("wd_apply_hold", int'(gain_apply), 'h200);
    cyc(1, 0, 0, 0, 0, 0);
    check("wd_pulse_end", int'(timeout), 0);
`else
    for (int i = 0; i < 1000; i++) cyc(1, 0, 0, 0, 0, 0);
    check("nowd_state", int'(state), 2);
    check("nowd_timeout", int'(timeout), 0);
`endif

    // Reset mid-slot with every other input active
    cyc(1, 1, 24'h0001C0, 1, 0, 0);
    check("mid_slot_state", int'(state), 2);
    cyc(1, 1, 24'h000300, 1, 1, 1);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_apply", int'(gain_apply), 'h100);
    check("mid_rst_capture", int'(gain_capture), 'h100);
    check("mid_rst_update", int'(gain_update), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_timeout", int'(timeout), 0);

    // Enable dropped mid-slot
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 24'h000280, 1, 0, 0);
    check("dis_slot_state", int'(state), 2);
    cyc(0, 0, 0, 0, 1, 0);
    check("dis_state", int'(state), 0);
    check("dis_apply", int'(gain_apply), 'h100);
    check("dis_update", int'(gain_update), 0);
    check("dis_locked", int'(locked), 0);

    // Randomized traffic, alternating busy and quiet slot activity
    for (int i = 0; i < 3000; i++) begin
      pct = ((i % 500) < 250) ? 10 : 2;
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: eg = 24'(($urandom_range(10) << 8) | $urandom_range(255));
        6:                eg = 24'($urandom);
        default:          eg = 24'h800000 | 24'($urandom_range(1023));
      endcase
      cyc($urandom_range(99) < 96, $urandom_range(9) < 6, eg,
          $urandom_range(99) < pct, $urandom_range(99) < pct,
          $urandom_range(199) == 0);
    end

    repeat (3) @(posedge aclk);
    #3;
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
